// File: rtl/div_radix2_iter_if.sv
// Request/response bundle between an M-extension issue stage and the radix-2 divider.
// Latency: none (wires only).
// Backpressure: requester holds start until ready; flush kills an in-flight operation.
//
// Ports:
//   start, op[1:0], dividend, divisor, flush : requester -> divider
//   ready, busy, result_valid, result        : divider -> requester
interface div_radix2_iter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  flush;
    logic                  ready;
    logic                  busy;
    logic                  result_valid;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  ready, busy, result_valid, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output ready, busy, result_valid, result
    );
endinterface

// File: rtl/div_radix2_iter.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: DATA_WIDTH+1 cycles accept-to-result_valid; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: one op at a time; start is only taken while ready (IDLE); flush abandons the op.
//
// Ports:
//   clk          rising-edge core clock
//   rst_n        synchronous active-low reset
//   bus (slave)  start/op/dividend/divisor/flush in; ready/busy/result_valid/result out
//
// op encoding: 00 DIV, 01 DIVU, 10 REM, 11 REMU. op[0]=1 means unsigned,
// op[1]=1 selects the remainder. CNT_WIDTH must satisfy 2**CNT_WIDTH > DATA_WIDTH.
module div_radix2_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    div_radix2_iter_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched operation context
    logic [1:0]            op_q;
    logic                  sign_a_q;   // raw dividend MSB at accept
    logic                  sign_b_q;   // raw divisor MSB at accept
    logic [DATA_WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [DATA_WIDTH-1:0] quo_q;      // dividend magnitude shifting out, quotient shifting in
    logic [DATA_WIDTH-1:0] rem_q;      // partial remainder
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] result_q;

    // ------------------------------------------------------------------
    // Accept-side decode (operates on the live request)
    // ------------------------------------------------------------------
    logic                  accept;
    logic                  in_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  div_zero;
    logic                  sgn_ovf;
    logic                  fast_path;
    logic [DATA_WIDTH-1:0] fast_result;

    always_comb begin
        accept    = (state_q == IDLE) && bus.start && !bus.flush;
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.dividend[DATA_WIDTH-1];
        b_neg     = in_signed & bus.divisor[DATA_WIDTH-1];
        // -MIN_NEG wraps to MIN_NEG, which is still the correct unsigned magnitude.
        a_mag     = a_neg ? -bus.dividend : bus.dividend;
        b_mag     = b_neg ? -bus.divisor  : bus.divisor;
        div_zero  = (bus.divisor == '0);
        sgn_ovf   = in_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
        fast_path = div_zero | sgn_ovf;

        // Divide-by-zero returns the raw dividend as remainder regardless of sign;
        // signed overflow gives quotient MIN_NEG and remainder 0.
        if (div_zero) begin
            fast_result = bus.op[1] ? bus.dividend : '1;
        end else begin
            fast_result = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    // ------------------------------------------------------------------
    // One restoring step per CALC cycle
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   partial;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;
    logic                  neg_quo;
    logic                  neg_rem;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;
    logic [DATA_WIDTH-1:0] calc_result;
    logic                  last_iter;

    always_comb begin
        partial = {rem_q, quo_q[DATA_WIDTH-1]};
        // Non-negative difference <=> partial >= divisor.
        q_bit   = (partial >= {1'b0, dvs_q});
        // When subtracting, the true difference is < divisor, so the low
        // DATA_WIDTH bits of a modular subtract are exact. When not, partial
        // is < divisor and therefore its top bit is zero.
        rem_nxt = q_bit ? (partial[DATA_WIDTH-1:0] - dvs_q) : partial[DATA_WIDTH-1:0];
        quo_nxt = {quo_q[DATA_WIDTH-2:0], q_bit};

        neg_quo     = ~op_q[0] & (sign_a_q ^ sign_b_q);
        neg_rem     = ~op_q[0] & sign_a_q;
        quo_fix     = neg_quo ? -quo_nxt : quo_nxt;
        rem_fix     = neg_rem ? -rem_nxt : rem_nxt;
        calc_result = op_q[1] ? rem_fix : quo_fix;
        last_iter   = (cnt_q == CNT_LAST);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.ready        = 1'b0;
        bus.busy         = 1'b0;
        bus.result_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (accept) begin
                    state_d = fast_path ? DONE : CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy         = 1'b1;
                bus.result_valid = ~bus.flush;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= bus.op;
            sign_a_q <= bus.dividend[DATA_WIDTH-1];
            sign_b_q <= bus.divisor[DATA_WIDTH-1];
            dvs_q    <= b_mag;
            quo_q    <= a_mag;
            rem_q    <= '0;
            cnt_q    <= CNT_INIT;
            if (fast_path) begin
                result_q <= fast_result;
            end
        end else if ((state_q == CALC) && !bus.flush) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CNT_LAST;
            // Result is captured together with the final quotient bit so it
            // is already stable in the DONE cycle.
            if (last_iter) begin
                result_q <= calc_result;
            end
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_div_radix2_iter.sv
module tb_div_radix2_iter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    div_radix2_iter_if #(.DATA_WIDTH(W)) bus ();

    div_radix2_iter #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] q;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = o[1] ? 64'(sa % sb) : 64'(sa / sb);
        end else begin
            q  = o[1] ? ({32'd0, a} % {32'd0, b}) : ({32'd0, a} / {32'd0, b});
        end
        return q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Issues one request at the next falling edge and follows it to result_valid.
    // lat counts falling edges after the accept edge (1 = the cycle right after accept);
    // lat = 0 means no result within the budget.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cyc,
                          output logic rdy_at_start);
        @(negedge clk);
        rdy_at_start = bus.ready;
        bus.start    = 1'b1;
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        lat      = 0;
        busy_cyc = 0;
        res      = 'x;
        @(negedge clk);
        // Operands are free to change once accepted.
        bus.start    = 1'b0;
        bus.op       = 2'($urandom);
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.result_valid) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.flush = 1'b0; bus.op = 2'b01;
        bus.dividend = 32'd100; bus.divisor = 32'd7;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: ready=%b busy=%b valid=%b, required 1 0 0", bus.ready, bus.busy, bus.result_valid);
        end
        tests++;
        if (bus.result !== 32'd0) begin
            fails++;
            $display("FAIL reset_result: got %h, required 0", bus.result);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: ready=%b busy=%b, required 1 0", bus.ready, bus.busy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7];
        logic [31:0] as  [7];
        logic [31:0] bs  [7];
        logic [31:0] exp_res [7];
        int          exp_lat [7];
        logic [31:0] res;
        int          lat;
        int          bc;
        logic        rdy;
        ops = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10};
        as  = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        bs  = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp_res = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        exp_lat = '{33, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bc, rdy);
            tests++;
            if (res !== exp_res[i]) begin
                fails++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, exp_res[i]);
            end
            tests++;
            if (lat != exp_lat[i] || bc != exp_lat[i]) begin
                fails++;
                $display("FAIL directed_latency[%0d]: valid at %0d busy for %0d, required %0d", i, lat, bc, exp_lat[i]);
            end
            @(negedge clk);
            tests++;
            if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp_res[i]) begin
                fails++;
                $display("FAIL directed_after_done[%0d]: ready=%b busy=%b result=%h, required 1 0 %h",
                         i, bus.ready, bus.busy, bus.result, exp_res[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          bc;
        logic        rdy;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 20)); end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            // Back-to-back: each run_op starts on the first cycle ready is back.
            run_op(o, a, b, res, lat, bc, rdy);
            tests++;
            if (rdy !== 1'b1 || res !== model(o, a, b) || lat != model_lat(o, a, b)) begin
                fails++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: ready=%b result=%h lat=%0d, required 1 %h %0d",
                         i, o, a, b, rdy, res, lat, model(o, a, b), model_lat(o, a, b));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] old_res;
        logic        seen;
        int          lat;
        // flush with start in IDLE: request dropped
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01;
        bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(negedge clk);
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_start: ready=%b busy=%b, required 1 0", bus.ready, bus.busy);
        end
        bus.flush = 1'b0;
        // flush mid-CALC
        bus.start = 1'b1; bus.op = 2'b01;
        bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'd1;
        old_res = bus.result;
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.result_valid) seen = 1'b1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.result_valid) seen = 1'b1;
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || seen !== 1'b0) begin
            fails++;
            $display("FAIL flush_calc: ready=%b busy=%b valid_seen=%b, required 1 0 0", bus.ready, bus.busy, seen);
        end
        tests++;
        if (bus.result !== old_res) begin
            fails++;
            $display("FAIL flush_keeps_result: got %h, required %h", bus.result, old_res);
        end
        bus.flush = 1'b0;
        bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd9; bus.divisor = 32'd3;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.result_valid) begin
                lat = k;
                break;
            end
        end
        tests++;
        if (lat != 33 || bus.result !== 32'd3) begin
            fails++;
            $display("FAIL flush_then_new: lat=%0d result=%h, required 33 00000003", lat, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int          lat;
        logic [31:0] res;
        int          extra;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd10;
        lat = 0;
        res = 'x;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.start = (k == 4);
            if (k == 4) begin
                bus.op = 2'b11; bus.dividend = 32'd77; bus.divisor = 32'd0;
            end
            if (bus.result_valid) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (lat != 33 || res !== 32'd100) begin
            fails++;
            $display("FAIL start_while_busy: lat=%0d result=%h, required 33 00000064", lat, res);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.result_valid) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL no_queued_result: got %0d extra results, required 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.dividend = 32'd12345; bus.divisor = 32'd17;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_midop: ready=%b busy=%b result=%h valid=%b, required 1 0 0 0",
                     bus.ready, bus.busy, bus.result, bus.result_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
        bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_ignored();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_radix2_iter.md
Name: div_radix2_iter

Overview:
- Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Performs the inverse operation of the core's Booth multiplier path and sits beside it in the EX-stage M-extension unit.
- Accepts one operation at a time via a start/ready handshake, iterates one quotient bit per cycle, and returns a single-cycle result_valid pulse.
- Divide-by-zero and signed-overflow cases bypass iteration.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; accepted only when ready=1.
- op  input  2  00 DIV (signed quot), 01 DIVU, 10 REM (signed rem), 11 REMU.
- dividend  input  DATA_WIDTH  rs1 value, sampled on accept.
- divisor  input  DATA_WIDTH  rs2 value, sampled on accept.
- flush  input  1  pipeline kill; abandons the current operation.
- ready  output  1  high only in IDLE.
- busy  output  1  high in CALC and DONE.
- result_valid  output  1  one-cycle pulse in DONE.
- result  output  DATA_WIDTH  quotient or remainder per the latched op; held until the next accept.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; ready=1, busy=0, result_valid=0, result=0.
  - All internal registers are cleared.
  - Reset overrides start and flush.
- States: IDLE, CALC, DONE.
- Accept condition: start=1 in IDLE. The block latches op, the sign flags, and the operand magnitudes.
  - Signed ops take |x| via two's complement; unsigned ops take x as-is.
  - Counter is loaded with DATA_WIDTH.
- IDLE -> DONE directly (fast path), result available next cycle:
  - divisor==0: quotient = all ones; remainder = dividend (unmodified, any sign).
  - op=DIV/REM with dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- IDLE -> CALC otherwise.
- CALC, each cycle:
  - Form partial = {rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]} (DATA_WIDTH+1 bits).
  - Compute diff = partial - {1'b0, divisor_mag}.
  - If diff is non-negative: rem <= diff, new quotient bit = 1. Otherwise: rem <= partial, new quotient bit = 0.
  - quo shifts left with the new bit in the LSB. Counter decrements.
  - Leave for DONE after the cycle in which the counter reaches 1, i.e. exactly DATA_WIDTH CALC cycles.
- DONE, one cycle:
  - result_valid=1.
  - result is registered on entry to DONE, with sign fix-up applied:
    - quotient is negated if signed op and the operand signs differ;
    - remainder is negated if signed op and the dividend is negative.
  - Next state is IDLE.
- Latency:
  - Normal path: result_valid is high DATA_WIDTH+1 cycles after the accept edge (33 for the default). The next accept is possible the cycle after DONE.
  - Fast path: result_valid is high 1 cycle after the accept edge.
- Start handling:
  - start while busy=1 is ignored. Operands are not re-sampled, and there is no queueing.
  - The requester holds start until it observes ready.
- Flush:
  - flush=1 in CALC or DONE forces IDLE on the next edge; result_valid is suppressed that cycle; result keeps its old value.
  - flush=1 in IDLE with start=1: flush wins and the request is not accepted.
- Operand hold: dividend, divisor and op may change freely after the accept edge.

Test Plan:
- DIVU 100 / 7: start at T0 -> result_valid at T0+33, result = 14; ready returns at T0+34.
- REM -7 / 2 (0xFFFFFFF9, 0x2) -> result = 0xFFFFFFFF (-1). DIV of the same operands -> 0xFFFFFFFD (-3).
- DIV 5 / 0 -> result_valid at T0+1, result = 0xFFFFFFFF. REMU 5 / 0 -> result = 5. busy is high for exactly 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> result = 0x80000000 at T0+1. REM of the same operands -> 0.
- DIVU 0xFFFFFFFF / 1 started, flush asserted at T0+10 -> IDLE and ready=1 at T0+11, no result_valid. A new DIVU 9 / 3 accepted at T0+11 -> result = 3 at T0+44.
- Second start pulsed at T0+5 during CALC -> ignored; only the first operation's result is produced. rst_n=0 at T0+20 -> ready=1, busy=0, result=0 on the next edge.
